// File: rtl/imem_loader.sv
// Byte-stream program loader for the instruction memory; holds the core in reset until an image is accepted.
// Optional CHECKSUM_EN macro adds a trailing XOR checksum byte that is verified before release.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imu_wen,
  output logic [ADDR_W-1:0] imu_addr,
  output logic [31:0]       imu_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_error
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  // word_idx must cover both the image length and the address slice taken from it
  localparam int IDX_W = (CNT_W > ADDR_W) ? CNT_W : ADDR_W;
  localparam logic [31:0] MAX_W32 = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              xfer;
  logic [7:0]        n_words;
  logic [IDX_W-1:0]  word_idx;
  logic [1:0]        byte_cnt;
  logic [23:0]       word_sr;
  logic              last_word;
  logic              count_too_big;
`ifdef CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign xfer          = byte_valid & byte_ready;
  assign last_word     = (32'(word_idx) + 32'd1) == {24'd0, n_words};
  assign count_too_big = {24'd0, byte_data} > MAX_W32;

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = COUNT;
      COUNT: begin
        if (xfer) begin
          if (count_too_big) begin
            state_nxt = ERROR;
          end else if (byte_data == 8'd0) begin
`ifdef CHECKSUM_EN
            state_nxt = CHECK;
`else
            state_nxt = DONE;
`endif
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (xfer && byte_cnt == 2'd3) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (last_word) begin
`ifdef CHECKSUM_EN
          state_nxt = CHECK;
`else
          state_nxt = DONE;
`endif
        end else begin
          state_nxt = DATA;
        end
      end
`ifdef CHECKSUM_EN
      CHECK: begin
        if (xfer) begin
          state_nxt = (byte_data == csum) ? DONE : ERROR;
        end
      end
`endif
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    imu_wen    = 1'b0;
    load_done  = 1'b0;
    load_error = 1'b0;
    case (state)
      COUNT, DATA, CHECK: byte_ready = 1'b1;
      WRITE:              imu_wen    = 1'b1;
      DONE:               load_done  = 1'b1;
      ERROR:              load_error = 1'b1;
      default: ;
    endcase
    cpu_hold = ~load_done;
  end

  // The write address/data are captured on the 4th byte so they stay stable after WRITE
  always_ff @(posedge clk) begin
    if (clr) begin
      n_words  <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      word_sr  <= '0;
      imu_addr <= '0;
      imu_data <= '0;
`ifdef CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      case (state)
        COUNT: begin
          if (xfer) begin
            n_words <= byte_data;
`ifdef CHECKSUM_EN
            csum    <= byte_data;
`endif
          end
        end
        DATA: begin
          if (xfer) begin
            word_sr  <= {word_sr[15:0], byte_data};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef CHECKSUM_EN
            csum     <= csum ^ byte_data;
`endif
            if (byte_cnt == 2'd3) begin
              imu_addr <= word_idx[ADDR_W-1:0];
              imu_data <= {word_sr, byte_data};
            end
          end
        end
        WRITE: word_idx <= word_idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (MAX_WORDS overridden to 4 to reach the limit cases).
module tb_imem_loader;

  logic        clk;
  logic        clr;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imu_wen;
  logic [7:0]  imu_addr;
  logic [31:0] imu_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  int unsigned vectors;
  int unsigned miscompares;

  int unsigned wr_cnt;
  logic [7:0]  wr_addr [0:31];
  logic [31:0] wr_data [0:31];

  imem_loader #(.ADDR_W(8), .MAX_WORDS(4)) dut (
    .clk        (clk),
    .clr        (clr),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imu_wen    (imu_wen),
    .imu_addr   (imu_addr),
    .imu_data   (imu_data),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial wr_cnt = 0;
  always @(negedge clk) begin
    if (imu_wen === 1'b1) begin
      if (wr_cnt < 32) begin
        wr_addr[wr_cnt] = imu_addr;
        wr_data[wr_cnt] = imu_data;
      end
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset;
    clr = 1'b1;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    step(1);
    clr = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int unsigned n;
    n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    while (byte_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(byte_ready), 32'd1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic wait_end;
    int unsigned n;
    n = 0;
    while (load_done !== 1'b1 && load_error !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    chk("end_reached", 32'(load_done | load_error), 32'd1);
  endtask

  int unsigned base;
  logic [7:0] mw [0:15];

  initial begin
    vectors = 0;
    miscompares = 0;
    clr = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    step(2);

    // reset values
    clr = 1'b1;
    step(1);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_wen",   32'(imu_wen),    32'd0);
    chk("rst_addr",  32'(imu_addr),   32'd0);
    chk("rst_data",  imu_data,        32'd0);
    chk("rst_hold",  32'(cpu_hold),   32'd1);
    chk("rst_done",  32'(load_done),  32'd0);
    chk("rst_err",   32'(load_error), 32'd0);
    clr = 1'b0;
    step(1);
    chk("count_ready", 32'(byte_ready), 32'd1);

    // single word, no stalls
    base = wr_cnt;
    send(8'h01); send(8'h20); send(8'h08); send(8'h00); send(8'h05);
    chk("w1_wen",  32'(imu_wen),  32'd1);
    chk("w1_addr", 32'(imu_addr), 32'd0);
    chk("w1_data", imu_data,      32'h20080005);
    chk("w1_rdy",  32'(byte_ready), 32'd0);
    step(1);
    chk("w1_wen_off", 32'(imu_wen), 32'd0);
`ifdef CHECKSUM_EN
    send(8'h2C);
`endif
    chk("w1_done", 32'(load_done), 32'd1);
    chk("w1_hold", 32'(cpu_hold),  32'd0);
    chk("w1_err",  32'(load_error), 32'd0);
    byte_valid = 1'b1;
    byte_data = 8'h77;
    step(3);
    chk("w1_done_rdy", 32'(byte_ready), 32'd0);
    byte_valid = 1'b0;
    chk("w1_nwr",  wr_cnt - base, 32'd1);
    chk("w1_hold_addr", 32'(imu_addr), 32'd0);
    chk("w1_hold_data", imu_data, 32'h20080005);

    // three words with byte_valid toggled every other cycle
    do_reset;
    chk("rst2_done", 32'(load_done), 32'd0);
    chk("rst2_hold", 32'(cpu_hold),  32'd1);
    base = wr_cnt;
    send(8'h03); step(1);
    send(8'h11); step(1); send(8'h22); step(1); send(8'h33); step(1); send(8'h44); step(1);
    send(8'h55); step(1); send(8'h66); step(1); send(8'h77); step(1); send(8'h88); step(1);
    send(8'hDE); step(1); send(8'hAD); step(1); send(8'hBE); step(1); send(8'hEF);
`ifdef CHECKSUM_EN
    step(1);
    send(8'hA9);
`endif
    wait_end;
    chk("w3_done", 32'(load_done), 32'd1);
    step(4);
    chk("w3_nwr", wr_cnt - base, 32'd3);
    chk("w3_a0", 32'(wr_addr[base]),     32'd0);
    chk("w3_d0", wr_data[base],          32'h11223344);
    chk("w3_a1", 32'(wr_addr[base + 1]), 32'd1);
    chk("w3_d1", wr_data[base + 1],      32'h55667788);
    chk("w3_a2", 32'(wr_addr[base + 2]), 32'd2);
    chk("w3_d2", wr_data[base + 2],      32'hDEADBEEF);
    chk("w3_hold_addr", 32'(imu_addr), 32'd2);
    chk("w3_hold_data", imu_data, 32'hDEADBEEF);

    // empty image
    do_reset;
    base = wr_cnt;
    send(8'h00);
`ifdef CHECKSUM_EN
    send(8'h00);
`endif
    chk("n0_done", 32'(load_done), 32'd1);
    chk("n0_hold", 32'(cpu_hold),  32'd0);
    step(2);
    chk("n0_nwr", wr_cnt - base, 32'd0);

    // count above MAX_WORDS
    do_reset;
    base = wr_cnt;
    send(8'h05);
    chk("big_err",  32'(load_error), 32'd1);
    chk("big_hold", 32'(cpu_hold),   32'd1);
    chk("big_done", 32'(load_done),  32'd0);
    chk("big_rdy",  32'(byte_ready), 32'd0);
    byte_valid = 1'b1;
    byte_data = 8'h01;
    step(4);
    chk("big_rdy_later", 32'(byte_ready), 32'd0);
    chk("big_err_later", 32'(load_error), 32'd1);
    byte_valid = 1'b0;
    chk("big_nwr", wr_cnt - base, 32'd0);

    // count exactly MAX_WORDS
    do_reset;
    base = wr_cnt;
    for (int i = 0; i < 16; i++) mw[i] = 8'(i);
    send(8'h04);
    for (int i = 0; i < 16; i++) send(mw[i]);
`ifdef CHECKSUM_EN
    wait_end_or_check: begin
      int unsigned n;
      n = 0;
      while (byte_ready !== 1'b1 && n < 10) begin step(1); n++; end
    end
    send(8'h04);
`endif
    wait_end;
    chk("max_done", 32'(load_done), 32'd1);
    chk("max_nwr",  wr_cnt - base, 32'd4);
    chk("max_a3",   32'(wr_addr[base + 3]), 32'd3);
    chk("max_d3",   wr_data[base + 3], 32'h0C0D0E0F);
    chk("max_d0",   wr_data[base], 32'h00010203);

`ifdef CHECKSUM_EN
    // wrong checksum
    do_reset;
    base = wr_cnt;
    send(8'h01); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h00);
    chk("cs_err",  32'(load_error), 32'd1);
    chk("cs_done", 32'(load_done),  32'd0);
    chk("cs_hold", 32'(cpu_hold),   32'd1);
    chk("cs_nwr",  wr_cnt - base, 32'd1);
    chk("cs_a0",   32'(wr_addr[base]), 32'd0);
    chk("cs_d0",   wr_data[base], 32'h11223344);
`endif

    // clr in the middle of a word, then a fresh image
    do_reset;
    base = wr_cnt;
    send(8'h02); send(8'h12); send(8'h34);
    clr = 1'b1;
    step(1);
    chk("mid_rdy",  32'(byte_ready), 32'd0);
    chk("mid_hold", 32'(cpu_hold),   32'd1);
    clr = 1'b0;
    send(8'h01); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
`ifdef CHECKSUM_EN
    step(1);
    send(8'h01);
`endif
    wait_end;
    chk("mid_done", 32'(load_done), 32'd1);
    chk("mid_nwr",  wr_cnt - base, 32'd1);
    chk("mid_a0",   32'(wr_addr[base]), 32'd0);
    chk("mid_d0",   wr_data[base], 32'hAABBCCDD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
